// File: rtl/bongo_pkg.sv
// Shared types and constants for the bongo report decoder: event ids,
// report field positions, the queued event record and a frame check helper.
package bongo_pkg;

    localparam int unsigned EVT_ID_W = 3;
    localparam int unsigned VEL_W    = 8;
    localparam int unsigned NUM_SRC  = 6;  // four pads, Start, clap

    localparam logic [EVT_ID_W-1:0] EVT_PAD_A = 3'd0;
    localparam logic [EVT_ID_W-1:0] EVT_PAD_B = 3'd1;
    localparam logic [EVT_ID_W-1:0] EVT_PAD_X = 3'd2;
    localparam logic [EVT_ID_W-1:0] EVT_PAD_Y = 3'd3;
    localparam logic [EVT_ID_W-1:0] EVT_START = 3'd4;
    localparam logic [EVT_ID_W-1:0] EVT_CLAP  = 3'd5;

    // Report field positions; bit 63 is first on the wire.
    localparam int unsigned HDR_HI    = 63;
    localparam int unsigned HDR_LO    = 61;
    localparam int unsigned START_BIT = 60;
    localparam int unsigned PAD_HI    = 59;
    localparam int unsigned PAD_LO    = 56;
    localparam int unsigned SYNC_BIT  = 55;
    localparam int unsigned MIC_HI    = 15;
    localparam int unsigned MIC_LO    = 8;

    typedef struct packed {
        logic [EVT_ID_W-1:0] id;
        logic [VEL_W-1:0]    vel;
    } evt_t;

    // A report is well-formed when its header is zero and the sync bit is set.
    function automatic logic frame_ok(input logic [63:0] f);
        return (f[HDR_HI:HDR_LO] == 3'b000) && f[SYNC_BIT];
    endfunction

endpackage

// File: rtl/bongo_report_decoder_if.sv
// Event stream from the decoder to the game logic (valid/ready handshake).
interface bongo_report_decoder_if;
    import bongo_pkg::*;

    logic                evt_valid;
    logic                evt_ready;
    logic [EVT_ID_W-1:0] evt_id;
    logic [VEL_W-1:0]    evt_vel;

    modport master (output evt_valid, output evt_id, output evt_vel, input evt_ready);
    modport slave  (input evt_valid, input evt_id, input evt_vel, output evt_ready);

endinterface

// File: rtl/event_fifo.sv
// Synchronous FIFO of decoded events. A write while full is accepted only
// when a read happens in the same cycle; the caller detects drops.
module event_fifo
    import bongo_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wr_en,
    input  evt_t wr_data,
    input  logic rd_en,
    output evt_t rd_data,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    evt_t        mem [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        do_wr, do_rd;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    // Head is forced to zero when empty so outputs are clean after reset.
    assign rd_data = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

    // Read/write pointers with a wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage array; contents need no reset since the pointers gate them.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/bongo_report_decoder.sv
// DK-bongo report decoder: validates 64-bit reports, debounces pads/Start,
// detects claps from the mic byte and queues hit/clap events with velocity.
// Also tracks mic level/peak, link presence and frame errors for display.
module bongo_report_decoder
    import bongo_pkg::*;
#(
    parameter int unsigned DEBOUNCE_FRAMES = 2,
    parameter logic [7:0]  CLAP_THRESH     = 8'hC0,
    parameter int unsigned CLAP_FRAMES     = 3,
    parameter int unsigned DECAY_DIV       = 50000,
    parameter int unsigned TIMEOUT_CYCLES  = 1250000,
    parameter int unsigned FIFO_DEPTH      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_valid,
    input  logic [63:0]                   frame_data,
    input  logic                          clear_flags,
    bongo_report_decoder_if.master        evt,
    output logic [3:0]                    pad_state,
    output logic                          start_state,
    output logic [7:0]                    mic_level,
    output logic [7:0]                    mic_peak,
    output logic                          link_up,
    output logic [7:0]                    err_count,
    output logic                          overflow
);

    localparam int unsigned NumBtn = 5;
    localparam int unsigned DivW   = $clog2(DECAY_DIV + 1);
    localparam int unsigned TmoW   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0]      DebN    = 3'(DEBOUNCE_FRAMES);
    localparam logic [7:0]      ClapN   = 8'(CLAP_FRAMES);
    localparam logic [DivW-1:0] DivLast = DivW'(DECAY_DIV - 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
    localparam logic [TmoW-1:0] TmoMax  = TmoW'(TIMEOUT_CYCLES);

    logic              accept, reject, expire;
    logic [NumBtn-1:0] raw_btn;
    logic [7:0]        mic;

    logic [NumBtn-1:0]      deb_q, deb_d, btn_rise;
    logic [NumBtn-1:0][2:0] deb_cnt_q, deb_cnt_d;
    logic [7:0]             loud_q, loud_d;
    logic                   clap_rise;

    logic [NUM_SRC-1:0]  pending_q, pending_d, drain_sel;
    logic [EVT_ID_W-1:0] drain_id;
    logic                push_req, pop, drop;
    logic                fifo_full, fifo_empty;
    evt_t                push_evt, head_evt;

    // mic_level doubles as the velocity latch: both hold the newest accepted mic.
    logic [7:0]      mic_level_q, peak_q, peak_d, err_q, err_d;
    logic [DivW-1:0] div_q, div_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            link_q, link_d, ovf_q, ovf_d, decay_tick;

    assign accept  = frame_valid && frame_ok(frame_data);
    assign reject  = frame_valid && !frame_ok(frame_data);
    assign raw_btn = {frame_data[START_BIT], frame_data[PAD_HI:PAD_LO]};
    assign mic     = frame_data[MIC_HI:MIC_LO];
    // Link times out only on the cycle the idle count reaches the limit.
    assign expire  = !accept && (tmo_q == TmoLast);

    // Per-button debounce and loud-run counting on accepted frames.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = deb_cnt_q;
        btn_rise  = '0;
        loud_d    = loud_q;
        clap_rise = 1'b0;
        if (expire) begin
            deb_d     = '0;
            deb_cnt_d = '0;
            loud_d    = '0;
        end else if (accept) begin
            for (int b = 0; b < NumBtn; b++) begin
                if (raw_btn[b] != deb_q[b]) begin
                    if (deb_cnt_q[b] == DebN - 3'd1) begin
                        deb_d[b]     = raw_btn[b];
                        deb_cnt_d[b] = '0;
                        btn_rise[b]  = raw_btn[b];
                    end else begin
                        deb_cnt_d[b] = deb_cnt_q[b] + 3'd1;
                    end
                end else begin
                    deb_cnt_d[b] = '0;
                end
            end
            if (mic >= CLAP_THRESH) begin
                // Saturate at the clap length so a long run yields one clap.
                if (loud_q != ClapN) begin
                    loud_d    = loud_q + 8'd1;
                    clap_rise = ((loud_q + 8'd1) == ClapN);
                end
            end else begin
                loud_d = '0;
            end
        end
    end

    // Pick the lowest pending source to push this cycle.
    always_comb begin
        drain_sel = '0;
        drain_id  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                drain_sel    = '0;
                drain_sel[i] = 1'b1;
                drain_id     = EVT_ID_W'(i);
            end
        end
    end

    assign push_req     = (|pending_q) && !expire;
    assign pending_d    = expire ? '0 : ((pending_q & ~drain_sel) | {clap_rise, btn_rise});
    assign push_evt.id  = drain_id;
    assign push_evt.vel = mic_level_q;
    assign pop          = !fifo_empty && evt.evt_ready;
    assign drop         = push_req && fifo_full && !pop;

    // Debounce, clap and pending state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q     <= '0;
            deb_cnt_q <= '0;
            loud_q    <= '0;
            pending_q <= '0;
        end else begin
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            loud_q    <= loud_d;
            pending_q <= pending_d;
        end
    end

    event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_event_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push_req),
        .wr_data (push_evt),
        .rd_en   (pop),
        .rd_data (head_evt),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign evt.evt_valid = !fifo_empty;
    assign evt.evt_id    = head_evt.id;
    assign evt.evt_vel   = head_evt.vel;

    // Mic peak-hold with a free-running decay divider; a louder frame wins.
    always_comb begin
        decay_tick = (div_q == DivLast);
        div_d      = decay_tick ? '0 : div_q + DivW'(1);
        peak_d     = peak_q;
        if (accept && (mic > peak_q)) begin
            peak_d = mic;
        end else if (decay_tick && (peak_q != 8'd0)) begin
            peak_d = peak_q - 8'd1;
        end
    end

    // Link timeout, error counter and sticky overflow next state.
    always_comb begin
        tmo_d  = tmo_q;
        link_d = link_q;
        if (accept) begin
            tmo_d  = '0;
            link_d = 1'b1;
        end else begin
            if (tmo_q != TmoMax) tmo_d = tmo_q + TmoW'(1);
            if (expire) link_d = 1'b0;
        end
        err_d = err_q;
        if (clear_flags) begin
            err_d = '0;
        end else if (reject && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clear_flags) begin
            ovf_d = 1'b0;
        end
    end

    // Status registers feeding the display path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mic_level_q <= '0;
            peak_q      <= '0;
            div_q       <= '0;
            tmo_q       <= '0;
            link_q      <= 1'b0;
            err_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            if (accept) mic_level_q <= mic;
            peak_q <= peak_d;
            div_q  <= div_d;
            tmo_q  <= tmo_d;
            link_q <= link_d;
            err_q  <= err_d;
            ovf_q  <= ovf_d;
        end
    end

    assign pad_state   = deb_q[3:0];
    assign start_state = deb_q[4];
    assign mic_level   = mic_level_q;
    assign mic_peak    = peak_q;
    assign link_up     = link_q;
    assign err_count   = err_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_bongo_report_decoder.sv
// Directed bench for bongo_report_decoder with an event scoreboard.
module tb_bongo_report_decoder;
    import bongo_pkg::*;

    localparam int unsigned DIV = 16;
    localparam int unsigned TMO = 400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_valid = 1'b0;
    logic [63:0] frame_data = '0;
    logic        clear_flags = 1'b0;
    logic [3:0]  pad_state;
    logic        start_state, link_up, overflow;
    logic [7:0]  mic_level, mic_peak, err_count;

    bongo_report_decoder_if evt_if ();

    bongo_report_decoder #(
        .DEBOUNCE_FRAMES (2),
        .CLAP_THRESH     (8'hC0),
        .CLAP_FRAMES     (3),
        .DECAY_DIV       (DIV),
        .TIMEOUT_CYCLES  (TMO),
        .FIFO_DEPTH      (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .clear_flags (clear_flags),
        .evt         (evt_if),
        .pad_state   (pad_state),
        .start_state (start_state),
        .mic_level   (mic_level),
        .mic_peak    (mic_peak),
        .link_up     (link_up),
        .err_count   (err_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail = 0;
    int          cycle = 0;
    logic [10:0] exp_q[$];
    logic [10:0] obs_q[$];
    int          obs_cyc[$];
    logic [7:0]  p0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: record handshakes at the falling edge, return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (evt_if.evt_valid && evt_if.evt_ready) begin
            obs_q.push_back({evt_if.evt_id, evt_if.evt_vel});
            obs_cyc.push_back(cycle);
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic gap(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [63:0] mk(input logic [3:0] pads, input logic start,
                                       input logic [7:0] mic, input logic [2:0] hdr,
                                       input logic sync);
        logic [63:0] f;
        f = {$urandom, $urandom};
        f[63:61] = hdr;
        f[60] = start;
        f[59:56] = pads;
        f[55] = sync;
        f[15:8] = mic;
        return f;
    endfunction

    task automatic send(input logic [3:0] pads, input logic start, input logic [7:0] mic,
                        input logic [2:0] hdr = 3'b000, input logic sync = 1'b1);
        frame_data = mk(pads, start, mic, hdr, sync);
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
    endtask

    task automatic sb_check(input string tag, input logic consec);
        logic [10:0] o, e;
        chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        if (consec) begin
            for (int i = 1; i < obs_cyc.size(); i++)
                chk({tag, "_consec"}, 64'(obs_cyc[i]), 64'(obs_cyc[i-1] + 1));
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_evt"}, 64'(o), 64'(e));
        end
        obs_q.delete();
        exp_q.delete();
        obs_cyc.delete();
    endtask

    initial begin
        evt_if.evt_ready = 1'b1;
        gap(3);
        chk("rst_valid", 64'(evt_if.evt_valid), 64'(0));
        chk("rst_id", 64'({evt_if.evt_id, evt_if.evt_vel}), 64'(0));
        chk("rst_pad", 64'({start_state, pad_state}), 64'(0));
        chk("rst_mic", 64'({mic_level, mic_peak}), 64'(0));
        chk("rst_link", 64'(link_up), 64'(0));
        chk("rst_err", 64'(err_count), 64'(0));
        chk("rst_ovf", 64'(overflow), 64'(0));
        rst_n = 1'b1;
        gap(2);

        // Single frame: no debounce change yet, status updated at T+1.
        send(4'b0001, 1'b0, 8'h40);
        chk("one_pad", 64'(pad_state), 64'(4'b0000));
        chk("one_link", 64'(link_up), 64'(1));
        chk("one_mic", 64'(mic_level), 64'(8'h40));
        chk("one_peak", 64'(mic_peak), 64'(8'h40));
        gap(10);
        sb_check("single", 1'b0);
        // Second agreeing frame: pad flips at T+1, event visible at T+2.
        send(4'b0001, 1'b0, 8'h40);
        exp_q.push_back({EVT_PAD_A, 8'h40});
        chk("two_pad", 64'(pad_state), 64'(4'b0001));
        chk("two_valid_t1", 64'(evt_if.evt_valid), 64'(0));
        tick();
        chk("two_valid_t2", 64'(evt_if.evt_valid), 64'(1));
        gap(6);
        sb_check("pad_a", 1'b0);

        // Release A (no event), then A+Y+Start together.
        send(4'b0000, 1'b0, 8'h10); gap(7);
        send(4'b0000, 1'b0, 8'h10); gap(7);
        send(4'b1001, 1'b1, 8'h55); gap(7);
        send(4'b1001, 1'b1, 8'h55);
        exp_q.push_back({EVT_PAD_A, 8'h55});
        exp_q.push_back({EVT_PAD_Y, 8'h55});
        exp_q.push_back({EVT_START, 8'h55});
        chk("multi_pad", 64'({start_state, pad_state}), 64'(5'b11001));
        gap(8);
        sb_check("multi", 1'b1);
        send(4'b0000, 1'b0, 8'h10); gap(7);
        send(4'b0000, 1'b0, 8'h10); gap(7);
        sb_check("release", 1'b0);

        // Rejected frames count errors and change nothing else.
        send(4'b1111, 1'b1, 8'h99, 3'b000, 1'b0);
        chk("err_sync", 64'(err_count), 64'(1));
        gap(7);
        send(4'b1111, 1'b1, 8'h99, 3'b100, 1'b1);
        chk("err_hdr", 64'(err_count), 64'(2));
        chk("err_pad", 64'(pad_state), 64'(0));
        chk("err_mic", 64'(mic_level), 64'(8'h10));
        gap(7);
        clear_flags = 1'b1; tick(); clear_flags = 1'b0;
        chk("err_clear", 64'(err_count), 64'(0));
        clear_flags = 1'b1;
        send(4'b0000, 1'b0, 8'h00, 3'b010, 1'b1);
        clear_flags = 1'b0;
        chk("err_clr_coinc", 64'(err_count), 64'(0));
        gap(7);
        sb_check("errors", 1'b0);

        // Two loud runs of five frames: one clap per run.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 5; k++) begin
                send(4'b0000, 1'b0, 8'hD0);
                if (k == 2) exp_q.push_back({EVT_CLAP, 8'hD0});
                if (r == 0 && k == 0) chk("clap_peak", 64'(mic_peak), 64'(8'hD0));
                gap(7);
            end
            send(4'b0000, 1'b0, 8'h10); gap(7);
        end
        sb_check("clap", 1'b0);

        // Stalled consumer: ten events, eight kept, overflow sticky.
        evt_if.evt_ready = 1'b0;
        send(4'b1111, 1'b1, 8'h21); gap(7);
        send(4'b1111, 1'b1, 8'h21); gap(7);
        send(4'b0000, 1'b0, 8'h10); gap(7);
        send(4'b0000, 1'b0, 8'h10); gap(7);
        send(4'b1111, 1'b1, 8'h22); gap(7);
        send(4'b1111, 1'b1, 8'h22); gap(7);
        exp_q.push_back({EVT_PAD_A, 8'h21});
        exp_q.push_back({EVT_PAD_B, 8'h21});
        exp_q.push_back({EVT_PAD_X, 8'h21});
        exp_q.push_back({EVT_PAD_Y, 8'h21});
        exp_q.push_back({EVT_START, 8'h21});
        exp_q.push_back({EVT_PAD_A, 8'h22});
        exp_q.push_back({EVT_PAD_B, 8'h22});
        exp_q.push_back({EVT_PAD_X, 8'h22});
        chk("ovf_set", 64'(overflow), 64'(1));
        chk("ovf_valid", 64'(evt_if.evt_valid), 64'(1));
        chk("ovf_head", 64'({evt_if.evt_id, evt_if.evt_vel}), 64'({EVT_PAD_A, 8'h21}));
        gap(3);
        chk("ovf_head_stable", 64'({evt_if.evt_id, evt_if.evt_vel}), 64'({EVT_PAD_A, 8'h21}));
        evt_if.evt_ready = 1'b1;
        gap(12);
        sb_check("ovf", 1'b1);
        chk("ovf_sticky", 64'(overflow), 64'(1));
        clear_flags = 1'b1; tick(); clear_flags = 1'b0;
        chk("ovf_clear", 64'(overflow), 64'(0));
        send(4'b0000, 1'b0, 8'h10); gap(7);
        send(4'b0000, 1'b0, 8'h10); gap(7);

        // Timeout with pad held, and peak decay.
        send(4'b0001, 1'b0, 8'hFF);
        chk("to_peak_load", 64'(mic_peak), 64'(8'hFF));
        gap(7);
        send(4'b0001, 1'b0, 8'hFF);
        exp_q.push_back({EVT_PAD_A, 8'hFF});
        gap(8);
        sb_check("to_press", 1'b0);
        gap(100);
        chk("to_link_still", 64'(link_up), 64'(1));
        p0 = mic_peak;
        gap(5 * DIV);
        chk("to_decay", 64'(mic_peak), 64'(p0 - 8'd5));
        gap(TMO);
        chk("to_link_down", 64'(link_up), 64'(0));
        chk("to_pad_clear", 64'({start_state, pad_state}), 64'(0));
        sb_check("to_quiet", 1'b0);
        // Loud-run and debounce counters must have been cleared too.
        send(4'b0001, 1'b0, 8'hD0);
        chk("to_relink", 64'(link_up), 64'(1));
        gap(8);
        chk("to_pad_fresh", 64'(pad_state), 64'(0));
        sb_check("to_after", 1'b0);

        // Reset in the middle of a drain empties pending and the FIFO.
        evt_if.evt_ready = 1'b0;
        send(4'b1111, 1'b1, 8'h30); gap(7);
        send(4'b1111, 1'b1, 8'h30);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(evt_if.evt_valid), 64'(0));
        chk("mid_rst_pad", 64'({start_state, pad_state}), 64'(0));
        gap(2);
        rst_n = 1'b1;
        evt_if.evt_ready = 1'b1;
        gap(6);
        chk("mid_rst_link", 64'(link_up), 64'(0));
        sb_check("mid_rst", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
